// File: rtl/tag_ram_dp.sv
// tag_ram_dp: dual-port tag RAM with a valid bit per entry.
// It includes a hardware flush sequencer, fixed-priority arbitration
// for same-address write collisions, and a selectable cross-port
// read-during-write behaviour. Read data is registered (1-cycle latency).
module tag_ram_dp #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WR_PRIORITY = 0,
    parameter int RDW_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p0_cs,
    input  logic                  p0_we,
    input  logic                  p0_oe,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_rvalid,
    output logic                  p0_hit,
    output logic                  p0_wr_drop,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_cs,
    input  logic                  p1_we,
    input  logic                  p1_oe,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_rvalid,
    output logic                  p1_hit,
    output logic                  p1_wr_drop
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Last index visited by the flush walk; the counter wraps to 0 after it.
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Port 1 wins a same-address write collision when this is set.
    localparam logic P1_WINS = (WR_PRIORITY != 0) ? 1'b1 : 1'b0;
    // Cross-port read at the address being written returns the new data.
    localparam logic RDW_NEW = (RDW_MODE != 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Sequencer state
    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic [ADDR_WIDTH-1:0]   cnt_next_s;

    // Storage
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [DEPTH-1:0]        valid_r;

    // Request decode
    logic                    accept_s;
    logic                    p0_wr_req_s;
    logic                    p1_wr_req_s;
    logic                    p0_rd_req_s;
    logic                    p1_rd_req_s;
    logic                    collide_s;
    logic                    p0_wr_en_s;
    logic                    p1_wr_en_s;
    logic                    p0_lose_s;
    logic                    p1_lose_s;

    // Next values for the registered read outputs
    logic [DATA_WIDTH-1:0]   p0_rdata_next_s;
    logic                    p0_hit_next_s;
    logic [DATA_WIDTH-1:0]   p1_rdata_next_s;
    logic                    p1_hit_next_s;

    // Output registers
    logic [DATA_WIDTH-1:0]   p0_rdata_r;
    logic                    p0_rvalid_r;
    logic                    p0_hit_r;
    logic                    p0_wr_drop_r;
    logic [DATA_WIDTH-1:0]   p1_rdata_r;
    logic                    p1_rvalid_r;
    logic                    p1_hit_r;
    logic                    p1_wr_drop_r;

    // Flush sequencer next-state: walk every entry once, then return to idle.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_req) begin
                    state_next_s = ST_FLUSH;
                    cnt_next_s   = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = cnt_r;
                end
            end
            ST_FLUSH: begin
                cnt_next_s = cnt_r + IDX_ONE;
                if (cnt_r == LAST_IDX) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            default: begin
                state_next_s = ST_FLUSH;
                cnt_next_s   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Sequencer registers; reset parks in FLUSH so valid bits clear after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FLUSH;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign flush_busy = (state_r == ST_FLUSH);

    // Request decode and write-collision arbitration.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) & ~rst;
        p0_wr_req_s = accept_s & p0_cs & p0_we;
        p1_wr_req_s = accept_s & p1_cs & p1_we;
        p0_rd_req_s = accept_s & p0_cs & ~p0_we & p0_oe;
        p1_rd_req_s = accept_s & p1_cs & ~p1_we & p1_oe;
        collide_s   = p0_wr_req_s & p1_wr_req_s & (p0_addr == p1_addr);
        p0_lose_s   = collide_s & P1_WINS;
        p1_lose_s   = collide_s & ~P1_WINS;
        p0_wr_en_s  = p0_wr_req_s & ~p0_lose_s;
        p1_wr_en_s  = p1_wr_req_s & ~p1_lose_s;
    end

    // Port 0 read path: array contents, or port 1's write data when bypassing.
    always_comb begin
        p0_rdata_next_s = {DATA_WIDTH{1'b0}};
        p0_hit_next_s   = 1'b0;
        if (p0_rd_req_s) begin
            if (RDW_NEW && p1_wr_en_s && (p1_addr == p0_addr)) begin
                p0_rdata_next_s = p1_wdata;
                p0_hit_next_s   = 1'b1;
            end else begin
                p0_rdata_next_s = mem_r[p0_addr];
                p0_hit_next_s   = valid_r[p0_addr];
            end
        end else begin
            p0_rdata_next_s = {DATA_WIDTH{1'b0}};
            p0_hit_next_s   = 1'b0;
        end
    end

    // Port 1 read path: array contents, or port 0's write data when bypassing.
    always_comb begin
        p1_rdata_next_s = {DATA_WIDTH{1'b0}};
        p1_hit_next_s   = 1'b0;
        if (p1_rd_req_s) begin
            if (RDW_NEW && p0_wr_en_s && (p0_addr == p1_addr)) begin
                p1_rdata_next_s = p0_wdata;
                p1_hit_next_s   = 1'b1;
            end else begin
                p1_rdata_next_s = mem_r[p1_addr];
                p1_hit_next_s   = valid_r[p1_addr];
            end
        end else begin
            p1_rdata_next_s = {DATA_WIDTH{1'b0}};
            p1_hit_next_s   = 1'b0;
        end
    end

    // Data array writes; arbitration guarantees the two never hit one entry.
    always_ff @(posedge clk) begin
        if (p0_wr_en_s) begin
            mem_r[p0_addr] <= p0_wdata;
        end
        if (p1_wr_en_s) begin
            mem_r[p1_addr] <= p1_wdata;
        end
    end

    // Valid array: the flush walk clears one entry per cycle, writes set entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= valid_r;
        end else if (state_r == ST_FLUSH) begin
            valid_r[cnt_r] <= 1'b0;
        end else begin
            if (p0_wr_en_s) begin
                valid_r[p0_addr] <= 1'b1;
            end
            if (p1_wr_en_s) begin
                valid_r[p1_addr] <= 1'b1;
            end
        end
    end

    // Registered port outputs, forced to zero while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rdata_r   <= {DATA_WIDTH{1'b0}};
            p0_rvalid_r  <= 1'b0;
            p0_hit_r     <= 1'b0;
            p0_wr_drop_r <= 1'b0;
            p1_rdata_r   <= {DATA_WIDTH{1'b0}};
            p1_rvalid_r  <= 1'b0;
            p1_hit_r     <= 1'b0;
            p1_wr_drop_r <= 1'b0;
        end else begin
            p0_rdata_r   <= p0_rdata_next_s;
            p0_rvalid_r  <= p0_rd_req_s;
            p0_hit_r     <= p0_hit_next_s;
            p0_wr_drop_r <= p0_lose_s;
            p1_rdata_r   <= p1_rdata_next_s;
            p1_rvalid_r  <= p1_rd_req_s;
            p1_hit_r     <= p1_hit_next_s;
            p1_wr_drop_r <= p1_lose_s;
        end
    end

    assign p0_rdata   = p0_rdata_r;
    assign p0_rvalid  = p0_rvalid_r;
    assign p0_hit     = p0_hit_r;
    assign p0_wr_drop = p0_wr_drop_r;
    assign p1_rdata   = p1_rdata_r;
    assign p1_rvalid  = p1_rvalid_r;
    assign p1_hit     = p1_hit_r;
    assign p1_wr_drop = p1_wr_drop_r;

endmodule

// File: tb/tb_tag_ram_dp.sv
// tb_tag_ram_dp: two instances of tag_ram_dp share one stimulus stream.
// Instance A uses port-0 write priority and old-data read-during-write;
// instance B uses port-1 write priority and new-data read-during-write.
// A table-level model predicts every output cycle.
module tb_tag_ram_dp;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush_req;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_cs, p0_we, p0_oe, p1_cs, p1_we, p1_oe;

    logic          flush_busy [2];
    logic [DW-1:0] p0_rdata [2];
    logic [DW-1:0] p1_rdata [2];
    logic          p0_rvalid [2], p0_hit [2], p0_wr_drop [2];
    logic          p1_rvalid [2], p1_hit [2], p1_wr_drop [2];

    tag_ram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_PRIORITY(0), .RDW_MODE(0)) u_a (
        .clk(clk), .rst(rst), .flush_req(flush_req), .flush_busy(flush_busy[0]),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_cs(p0_cs), .p0_we(p0_we), .p0_oe(p0_oe),
        .p0_rdata(p0_rdata[0]), .p0_rvalid(p0_rvalid[0]), .p0_hit(p0_hit[0]), .p0_wr_drop(p0_wr_drop[0]),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_cs(p1_cs), .p1_we(p1_we), .p1_oe(p1_oe),
        .p1_rdata(p1_rdata[0]), .p1_rvalid(p1_rvalid[0]), .p1_hit(p1_hit[0]), .p1_wr_drop(p1_wr_drop[0])
    );

    tag_ram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_PRIORITY(1), .RDW_MODE(1)) u_b (
        .clk(clk), .rst(rst), .flush_req(flush_req), .flush_busy(flush_busy[1]),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_cs(p0_cs), .p0_we(p0_we), .p0_oe(p0_oe),
        .p0_rdata(p0_rdata[1]), .p0_rvalid(p0_rvalid[1]), .p0_hit(p0_hit[1]), .p0_wr_drop(p0_wr_drop[1]),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_cs(p1_cs), .p1_we(p1_we), .p1_oe(p1_oe),
        .p1_rdata(p1_rdata[1]), .p1_rvalid(p1_rvalid[1]), .p1_hit(p1_hit[1]), .p1_wr_drop(p1_wr_drop[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            cfg_wp  [2] = '{0, 1};
    int            cfg_rdw [2] = '{0, 1};
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_val   [2][DEPTH];
    bit            m_known [2][DEPTH];
    int            m_busy  [2];          // flush cycles still to run, 0 = idle
    logic [DW-1:0] e_rdata [2][2];
    bit            e_rvalid[2][2];
    bit            e_hit   [2][2];
    bit            e_drop  [2][2];
    bit            e_known [2][2];
    bit            started = 1'b0;

    task automatic clear_exp(input int k);
        for (int j = 0; j < 2; j++) begin
            e_rdata[k][j] = '0; e_rvalid[k][j] = 0; e_hit[k][j] = 0;
            e_drop[k][j] = 0;   e_known[k][j] = 1;
        end
    endtask

    task automatic model_step(input int k);
        logic [AW-1:0] a  [2];
        logic [DW-1:0] wd [2];
        bit            wr [2];
        bit            rd [2];
        int            o;
        a[0] = p0_addr;  a[1] = p1_addr;
        wd[0] = p0_wdata; wd[1] = p1_wdata;
        wr[0] = p0_cs && p0_we;  wr[1] = p1_cs && p1_we;
        rd[0] = p0_cs && !p0_we && p0_oe;
        rd[1] = p1_cs && !p1_we && p1_oe;
        clear_exp(k);
        if (rst) begin
            m_busy[k] = DEPTH;
        end else if (m_busy[k] > 0) begin
            m_val[k][DEPTH - m_busy[k]] = 0;
            m_busy[k]--;
        end else begin
            if (wr[0] && wr[1] && a[0] == a[1]) begin
                wr[1 - cfg_wp[k]]     = 0;
                e_drop[k][1 - cfg_wp[k]] = 1;
            end
            for (int j = 0; j < 2; j++) begin
                o = 1 - j;
                if (rd[j]) begin
                    e_rvalid[k][j] = 1;
                    if (cfg_rdw[k] == 1 && wr[o] && a[o] == a[j]) begin
                        e_rdata[k][j] = wd[o]; e_hit[k][j] = 1; e_known[k][j] = 1;
                    end else begin
                        e_rdata[k][j] = m_mem[k][a[j]];
                        e_hit[k][j]   = m_val[k][a[j]];
                        e_known[k][j] = m_known[k][a[j]];
                    end
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (wr[j]) begin
                    m_mem[k][a[j]] = wd[j]; m_val[k][a[j]] = 1; m_known[k][a[j]] = 1;
                end
            end
            if (flush_req) m_busy[k] = DEPTH;
        end
    endtask

    // Model advances on every rising edge using the inputs the DUTs see.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        started = 1'b1;
    end

    // Compare every output of both instances on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d.flush_busy", k), flush_busy[k], (m_busy[k] > 0));
                chk($sformatf("m%0d.p0_rvalid", k), p0_rvalid[k], e_rvalid[k][0]);
                chk($sformatf("m%0d.p1_rvalid", k), p1_rvalid[k], e_rvalid[k][1]);
                chk($sformatf("m%0d.p0_hit", k), p0_hit[k], e_hit[k][0]);
                chk($sformatf("m%0d.p1_hit", k), p1_hit[k], e_hit[k][1]);
                chk($sformatf("m%0d.p0_wr_drop", k), p0_wr_drop[k], e_drop[k][0]);
                chk($sformatf("m%0d.p1_wr_drop", k), p1_wr_drop[k], e_drop[k][1]);
                if (e_known[k][0]) chk($sformatf("m%0d.p0_rdata", k), p0_rdata[k], e_rdata[k][0]);
                if (e_known[k][1]) chk($sformatf("m%0d.p1_rdata", k), p1_rdata[k], e_rdata[k][1]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_in();
        flush_req = 1'b0;
        p0_cs = 1'b0; p0_we = 1'b0; p0_oe = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_cs = 1'b0; p1_we = 1'b0; p1_oe = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin p0_cs = 1'b1; p0_we = 1'b1; p0_oe = 1'b0; p0_addr = a; p0_wdata = d; end
        else           begin p1_cs = 1'b1; p1_we = 1'b1; p1_oe = 1'b0; p1_addr = a; p1_wdata = d; end
    endtask

    task automatic rd(input int port, input logic [AW-1:0] a);
        if (port == 0) begin p0_cs = 1'b1; p0_we = 1'b0; p0_oe = 1'b1; p0_addr = a; end
        else           begin p1_cs = 1'b1; p1_we = 1'b0; p1_oe = 1'b1; p1_addr = a; end
    endtask

    task automatic go();
        @(negedge clk);
    endtask

    // Count cycles flush_busy stays high from now, bounded.
    task automatic busy_len(input string name);
        int n;
        n = 0;
        while (flush_busy[0] && n < 40) begin
            go();
            n++;
        end
        chk(name, n, 16);
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        repeat (3) go();
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", flush_busy[k], 1);
            chk("reset_rvalid", p0_rvalid[k], 0);
            chk("reset_rdata", p1_rdata[k], 0);
        end
        rst = 1'b0;
        busy_len("post_reset_busy_len");

        // read of a never-written entry after the reset flush
        idle_in(); rd(0, 4'd3); go();
        for (int k = 0; k < 2; k++) begin
            chk("rd3_rvalid", p0_rvalid[k], 1);
            chk("rd3_hit", p0_hit[k], 0);
        end

        // cross-port write then read
        idle_in(); wr(0, 4'd5, 32'hDEADBEEF); go();
        idle_in(); rd(1, 4'd5); go();
        for (int k = 0; k < 2; k++) begin
            chk("rd5_data", p1_rdata[k], 32'hDEADBEEF);
            chk("rd5_hit", p1_hit[k], 1);
            chk("rd5_rvalid", p1_rvalid[k], 1);
        end
        idle_in(); go();
        for (int k = 0; k < 2; k++) begin
            chk("noread_rvalid", p1_rvalid[k], 0);
            chk("noread_rdata", p1_rdata[k], 0);
        end

        // same-address write collision
        idle_in(); wr(0, 4'd7, 32'h11); wr(1, 4'd7, 32'h22); go();
        chk("coll_a_p1_drop", p1_wr_drop[0], 1);
        chk("coll_a_p0_drop", p0_wr_drop[0], 0);
        chk("coll_b_p0_drop", p0_wr_drop[1], 1);
        chk("coll_b_p1_drop", p1_wr_drop[1], 0);
        idle_in(); rd(0, 4'd7); go();
        chk("coll_a_data", p0_rdata[0], 32'h11);
        chk("coll_b_data", p0_rdata[1], 32'h22);
        chk("coll_a_drop_once", p1_wr_drop[0], 0);
        chk("coll_b_drop_once", p0_wr_drop[1], 0);

        // cross-port read during write
        idle_in(); wr(0, 4'd9, 32'h55); go();
        idle_in(); wr(0, 4'd9, 32'hAA); rd(1, 4'd9); go();
        chk("rdw_old_data", p1_rdata[0], 32'h55);
        chk("rdw_new_data", p1_rdata[1], 32'hAA);
        chk("rdw_new_hit", p1_hit[1], 1);
        idle_in(); rd(0, 4'd9); go();
        chk("rdw_after_a", p0_rdata[0], 32'hAA);
        chk("rdw_after_b", p0_rdata[1], 32'hAA);

        // two writes to different addresses both land
        idle_in(); wr(0, 4'd1, 32'h100); wr(1, 4'd2, 32'h200); go();
        idle_in(); rd(0, 4'd2); rd(1, 4'd1); go();
        chk("dual_wr_p0", p0_rdata[0], 32'h200);
        chk("dual_wr_p1", p1_rdata[1], 32'h100);

        // fill, then flush with a same-cycle write that must land
        for (int i = 0; i < DEPTH; i++) begin
            idle_in(); wr(0, i[AW-1:0], 32'h1000 + i); go();
        end
        idle_in(); wr(1, 4'd4, 32'hF4); flush_req = 1'b1; go();
        chk("flush_busy_rise", flush_busy[0], 1);
        begin
            int n;
            n = 0;
            while (flush_busy[0] && n < 40) begin
                idle_in();
                rd(0, n[AW-1:0]);
                wr(1, n[AW-1:0], 32'hBAD);
                if (n == 5) flush_req = 1'b1;
                go();
                chk("flush_no_rvalid", p0_rvalid[1], 0);
                n++;
            end
            chk("flush_len", n, 16);
        end
        for (int i = 0; i < DEPTH; i++) begin
            idle_in(); rd(0, i[AW-1:0]); rd(1, 4'(15 - i)); go();
            chk("post_flush_hit", p0_hit[0], 0);
            chk("post_flush_data", p0_rdata[1], (i == 4) ? 32'hF4 : 32'h1000 + i);
        end

        // reset in the middle of a flush restarts it
        idle_in(); wr(0, 4'd12, 32'hC12); go();
        idle_in(); flush_req = 1'b1; go();
        idle_in(); repeat (8) go();
        rst = 1'b1; rd(0, 4'd12); wr(1, 4'd3, 32'h33);
        repeat (2) begin
            go();
            for (int k = 0; k < 2; k++) begin
                chk("rst_mid_busy", flush_busy[k], 1);
                chk("rst_mid_rvalid", p0_rvalid[k], 0);
                chk("rst_mid_rdata", p0_rdata[k], 0);
                chk("rst_mid_drop", p1_wr_drop[k], 0);
            end
        end
        rst = 1'b0; idle_in();
        busy_len("restart_busy_len");
        idle_in(); rd(0, 4'd12); rd(1, 4'd3); go();
        for (int k = 0; k < 2; k++) begin
            chk("restart_hit12", p0_hit[k], 0);
            chk("restart_data12", p0_rdata[k], 32'hC12);
            chk("rst_write_dropped", p1_rdata[k], 32'h1003);
        end

        idle_in(); go();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
